// File: rtl/jts16_snd_latch_rx.sv
// Sound-CPU end of the main-to-sound command latch.
// Build option: JTS16_SNDLATCH_FIFO_EN turns the holding latch into a 4-deep FIFO.
module jts16_snd_latch_rx #(
  parameter int         ACK_LEN  = 8,
  parameter logic [1:0] PORT_SEL = 2'b11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] snd_latch,
  input  logic       snd_irqn,
  output logic       snd_ack,
  input  logic       cen,
  input  logic [7:0] A,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       m1_n,
  output logic [7:0] dout,
  output logic       latch_cs,
  output logic       nmi_n,
  output logic       overrun
);

  logic       irq_l;
  logic       in_rd;
  logic       strobe;
  logic       rd_hit;
  logic       rd_first;
  logic [7:0] acnt;
  logic [7:0] rd_data;

  assign strobe   = irq_l & ~snd_irqn;
  assign rd_hit   = cen & ~iorq_n & ~rd_n & m1_n
                  & (A[7:6] == PORT_SEL);
  assign rd_first = rd_hit & ~in_rd;
  assign latch_cs = rd_hit;
  assign dout     = rd_hit ? rd_data : 8'hFF;

  // Edge-detect the strobe and remember an ongoing read access
  // so a long (cen-stretched) access counts as a single read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_l <= 1'b1;
      in_rd <= 1'b0;
    end else begin
      irq_l <= snd_irqn;
      in_rd <= rd_hit | (in_rd & ~iorq_n & ~rd_n);
    end
  end

`ifdef JTS16_SNDLATCH_FIFO_EN

  logic [7:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] cnt;
  logic [7:0] last;
  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic [2:0] cnt_nx;

  assign empty   = (cnt == 3'd0);
  assign full    = (cnt == 3'd4);
  assign pop     = rd_first & ~empty;
  assign push    = strobe & (~full | pop);
  assign rd_data = empty ? last : mem[rp];

  always_comb begin
    cnt_nx = cnt;
    if (push && !pop) cnt_nx = cnt + 3'd1;
    if (pop && !push) cnt_nx = cnt - 3'd1;
  end

  // FIFO storage, NMI follows non-empty, ack pulse after each pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp      <= 2'd0;
      rp      <= 2'd0;
      cnt     <= 3'd0;
      last    <= 8'h00;
      nmi_n   <= 1'b1;
      snd_ack <= 1'b0;
      acnt    <= 8'd0;
      overrun <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wp] <= snd_latch;
        wp      <= wp + 2'd1;
      end
      if (strobe && full && !pop) overrun <= 1'b1;
      if (pop) begin
        last <= mem[rp];
        rp   <= rp + 2'd1;
      end
      cnt   <= cnt_nx;
      nmi_n <= (cnt_nx == 3'd0);
      if (pop) begin
        snd_ack <= 1'b1;
        acnt    <= 8'(ACK_LEN);
      end else if (snd_ack) begin
        if (acnt <= 8'd1) begin
          snd_ack <= 1'b0;
          acnt    <= 8'd0;
        end else begin
          acnt <= acnt - 8'd1;
        end
      end
    end
  end

`else

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] held;

  assign rd_data = held;

  // Command handshake: capture, NMI, read, timed ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      held    <= 8'h00;
      nmi_n   <= 1'b1;
      snd_ack <= 1'b0;
      acnt    <= 8'd0;
      overrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (strobe) begin
            held  <= snd_latch;
            nmi_n <= 1'b0;
            state <= PEND;
          end
        end
        PEND: begin
          if (strobe) begin
            held <= snd_latch;
            if (!rd_first) overrun <= 1'b1;
          end else if (rd_first) begin
            nmi_n   <= 1'b1;
            snd_ack <= 1'b1;
            acnt    <= 8'(ACK_LEN);
            state   <= ACK;
          end
        end
        ACK: begin
          if (strobe) begin
            held    <= snd_latch;
            nmi_n   <= 1'b0;
            snd_ack <= 1'b0;
            acnt    <= 8'd0;
            state   <= PEND;
          end else if (acnt <= 8'd1) begin
            snd_ack <= 1'b0;
            acnt    <= 8'd0;
            state   <= IDLE;
          end else begin
            acnt <= acnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_jts16_snd_latch_rx.sv
// Directed bench for jts16_snd_latch_rx.
// Hand-computed expectations, one task per scenario.
module tb_jts16_snd_latch_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] snd_latch;
  logic       snd_irqn;
  logic       snd_ack;
  logic       cen;
  logic [7:0] A;
  logic       iorq_n;
  logic       rd_n;
  logic       m1_n;
  logic [7:0] dout;
  logic       latch_cs;
  logic       nmi_n;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jts16_snd_latch_rx dut (
    .clk(clk), .rst_n(rst_n),
    .snd_latch(snd_latch), .snd_irqn(snd_irqn),
    .snd_ack(snd_ack), .cen(cen), .A(A),
    .iorq_n(iorq_n), .rd_n(rd_n), .m1_n(m1_n),
    .dout(dout), .latch_cs(latch_cs),
    .nmi_n(nmi_n), .overrun(overrun)
  );

  task automatic bus_idle();
    cen    = 1'b1;
    A      = 8'h00;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    m1_n   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    snd_latch = b;
    snd_irqn  = 1'b0;
    @(negedge clk);
    snd_irqn  = 1'b1;
  endtask

  task automatic do_read(output logic [7:0] d,
                         output logic cs);
    @(negedge clk);
    A      = 8'hC0;
    iorq_n = 1'b0;
    rd_n   = 1'b0;
    #1;
    d  = dout;
    cs = latch_cs;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic cs;
    do_reset();
    n_cmp++;
    if (dout !== 8'hFF || latch_cs !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_bus dout=%h cs=%b want FF 0", dout, latch_cs);
    end
    n_cmp++;
    if (nmi_n !== 1'b1 || snd_ack !== 1'b0 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags nmi=%b ack=%b ovr=%b want 1 0 0",
               nmi_n, snd_ack, overrun);
    end
    do_read(d, cs);
    n_cmp++;
    if (d !== 8'h00 || cs !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_read dout=%h cs=%b want 00 1", d, cs);
    end
    n_cmp++;
    if (nmi_n !== 1'b1 || snd_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_read nmi=%b ack=%b want 1 0", nmi_n, snd_ack);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic cs;
    int hi;
    @(negedge clk);
    snd_latch = 8'h5A;
    snd_irqn  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (nmi_n !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_nmi nmi=%b want 0", nmi_n);
    end
    snd_irqn = 1'b1;
    do_read(d, cs);
    n_cmp++;
    if (d !== 8'h5A) begin
      n_bad++;
      $display("FAIL basic_read dout=%h want 5A", d);
    end
    n_cmp++;
    if (nmi_n !== 1'b1 || snd_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ack_start nmi=%b ack=%b want 1 1", nmi_n, snd_ack);
    end
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (snd_ack) hi++;
      @(negedge clk);
    end
    n_cmp++;
    if (hi !== 8) begin
      n_bad++;
      $display("FAIL basic_ack_len cycles=%0d want 8", hi);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic cs;
    do_reset();
    strobe(8'h11);
    strobe(8'h22);
    do_read(d, cs);
`ifdef JTS16_SNDLATCH_FIFO_EN
    n_cmp++;
    if (d !== 8'h11) begin
      n_bad++;
      $display("FAIL ovr_read1 dout=%h want 11", d);
    end
    repeat (10) @(negedge clk);
    do_read(d, cs);
    n_cmp++;
    if (d !== 8'h22 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_read2 dout=%h ovr=%b want 22 0", d, overrun);
    end
`else
    n_cmp++;
    if (d !== 8'h22 || overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_read dout=%h ovr=%b want 22 1", d, overrun);
    end
`endif
    repeat (12) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    logic cs;
    do_reset();
    strobe(8'h44);
    @(negedge clk);
    snd_latch = 8'h33;
    snd_irqn  = 1'b0;
    A      = 8'hC0;
    iorq_n = 1'b0;
    rd_n   = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 8'h44) begin
      n_bad++;
      $display("FAIL simul_old dout=%h want 44", dout);
    end
    @(negedge clk);
    bus_idle();
    snd_irqn = 1'b1;
    n_cmp++;
    if (nmi_n !== 1'b0 || snd_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_pend nmi=%b ack=%b want 0 0", nmi_n, snd_ack);
    end
    @(negedge clk);
    do_read(d, cs);
    n_cmp++;
    if (d !== 8'h33 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_next dout=%h ovr=%b want 33 0", d, overrun);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_hold_and_intack();
    logic [7:0] d;
    logic cs;
    logic prev;
    int falls;
    do_reset();
    falls = 0;
    prev  = nmi_n;
    @(negedge clk);
    snd_latch = 8'h77;
    snd_irqn  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prev && !nmi_n) falls++;
      prev = nmi_n;
      if (i == 50) begin
        A = 8'hC0; iorq_n = 1'b0; rd_n = 1'b0;
      end
      if (i == 51) bus_idle();
    end
    snd_irqn = 1'b1;
    n_cmp++;
    if (falls !== 1 || nmi_n !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_one_nmi falls=%0d nmi=%b want 1 1", falls, nmi_n);
    end
    repeat (12) @(negedge clk);
    strobe(8'h99);
    @(negedge clk);
    A = 8'hC0; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
    #1;
    n_cmp++;
    if (latch_cs !== 1'b0 || dout !== 8'hFF) begin
      n_bad++;
      $display("FAIL intack_cs cs=%b dout=%h want 0 FF", latch_cs, dout);
    end
    @(negedge clk);
    m1_n = 1'b1; cen = 1'b0;
    #1;
    n_cmp++;
    if (latch_cs !== 1'b0) begin
      n_bad++;
      $display("FAIL cen_gate cs=%b want 0", latch_cs);
    end
    @(negedge clk);
    bus_idle();
    @(negedge clk);
    n_cmp++;
    if (nmi_n !== 1'b0 || snd_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL intack_state nmi=%b ack=%b want 0 0", nmi_n, snd_ack);
    end
    do_read(d, cs);
    n_cmp++;
    if (d !== 8'h99) begin
      n_bad++;
      $display("FAIL intack_read dout=%h want 99", d);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_in_ack();
    logic [7:0] d;
    logic cs;
    do_reset();
    strobe(8'hA5);
    do_read(d, cs);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (snd_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ack_pre ack=%b want 1", snd_ack);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (snd_ack !== 1'b0 || nmi_n !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ack_post ack=%b nmi=%b want 0 1", snd_ack, nmi_n);
    end
    rst_n = 1'b1;
    do_read(d, cs);
    n_cmp++;
    if (d !== 8'h00 || snd_ack !== 1'b0 || nmi_n !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_ack_idle dout=%h ack=%b nmi=%b want 00 0 1",
               d, snd_ack, nmi_n);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    snd_latch = 8'h00;
    snd_irqn  = 1'b1;
    bus_idle();
    test_reset();
    test_basic();
    test_overrun();
    test_simultaneous();
    test_hold_and_intack();
    test_reset_in_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
